// File: rtl/board_pkg.sv
// Purpose : shared board definitions for the board memory read/write paths:
//           point encodings, board geometry, FSM states, coordinate helper.
// Latency : n/a (package).  Back-pressure: n/a.
package board_pkg;

  // Board geometry: 16x16 intersections, 2 bits per point, flat 512-bit image.
  localparam int BOARD_DIM   = 16;
  localparam int POINT_BITS  = 2;
  localparam int NUM_POINTS  = BOARD_DIM * BOARD_DIM;
  localparam int BOARD_BITS  = NUM_POINTS * POINT_BITS;
  localparam int COORD_BITS  = 8;
  localparam int OFFSET_BITS = 9;  // bit offset of a point, 0..510
  localparam int COUNT_BITS  = 9;  // holds 0..256 inclusive

  // Point encodings. 2'b11 is illegal: never counted, passed through as-is.
  localparam logic [POINT_BITS-1:0] EMPTY_CODE = 2'b00;
  localparam logic [POINT_BITS-1:0] BLACK_CODE = 2'b01;
  localparam logic [POINT_BITS-1:0] WHITE_CODE = 2'b10;

  // Raster position of the final point of a sweep.
  localparam logic [COORD_BITS-1:0] LAST_XY = 8'hFF;

  // Sweep engine states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  // Point (x,y) lives at bit (x*16+y)*2. Because y is exactly 4 bits,
  // x*16+y is just the concatenation {x,y}, so the offset is xy shifted by one.
  function automatic logic [OFFSET_BITS-1:0] point_offset(input logic [COORD_BITS-1:0] xy);
    return {xy, 1'b0};
  endfunction

endpackage

// File: rtl/board_point_mux.sv
// Purpose : 512->2 selector, returns the point stored at coordinate i_xy.
// Latency : combinational, 0 cycles.  Back-pressure: none.
// Ports   : i_board  - flat board image
//           i_xy     - coordinate {x[3:0], y[3:0]}
//           o_point  - 2-bit point value at i_xy
module board_point_mux
  import board_pkg::*;
(
  input  logic [BOARD_BITS-1:0] i_board,
  input  logic [COORD_BITS-1:0] i_xy,
  output logic [POINT_BITS-1:0] o_point
);

  logic [OFFSET_BITS-1:0] w_offset;

  assign w_offset = point_offset(i_xy);
  assign o_point  = i_board[w_offset +: POINT_BITS];

endmodule

// File: rtl/board_memory_read.sv
// Purpose : read side of the board memory. A random-access port answers
//           single-point queries; a sweep engine streams all 256 points in
//           raster order and tallies black and white stones.
// Latency : random read 1 cycle; sweep >= 256 SCAN cycles + 1 DONE cycle.
// Backpressure: random port has none; sweep stalls on scan_ready=0 with
//           scan_xy held, done pulse follows acceptance of the last beat.
// Ports   : clock/reset (sync, active-high), board (512-bit image),
//           rd_req/rd_select -> rd_valid/rd_data,
//           scan_start/scan_ready -> scan_valid/scan_xy/scan_data/scan_done,
//           busy, black_count, white_count.
module board_memory_read
  import board_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BOARD_BITS-1:0] board,
  // random-access port
  input  logic                  rd_req,
  input  logic [COORD_BITS-1:0] rd_select,
  output logic                  rd_valid,
  output logic [POINT_BITS-1:0] rd_data,
  // sweep port
  input  logic                  scan_start,
  input  logic                  scan_ready,
  output logic                  scan_valid,
  output logic [COORD_BITS-1:0] scan_xy,
  output logic [POINT_BITS-1:0] scan_data,
  output logic                  scan_done,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] black_count,
  output logic [COUNT_BITS-1:0] white_count
);

  // ------------------------------------------------------------------
  // Random-access port
  // ------------------------------------------------------------------
  logic [POINT_BITS-1:0] w_rd_point;
  logic                  r_rd_valid;
  logic [POINT_BITS-1:0] r_rd_data;

  board_point_mux u_rd_mux (
    .i_board (board),
    .i_xy    (rd_select),
    .o_point (w_rd_point)
  );

  // Independent of the sweep engine; rd_data holds its last value when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_rd_data <= w_rd_point;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

  // ------------------------------------------------------------------
  // Sweep engine
  // ------------------------------------------------------------------
  scan_state_t           r_state;
  logic [COORD_BITS-1:0] r_index;
  logic                  r_scan_valid;
  logic                  r_scan_done;
  logic                  r_busy;
  logic [COUNT_BITS-1:0] r_black_count;
  logic [COUNT_BITS-1:0] r_white_count;

  logic [POINT_BITS-1:0] w_scan_point;
  logic                  w_accept;

  // The sweep reads the live board, so a write during a stall is visible and
  // the value present on the accepting edge is the one that gets counted.
  board_point_mux u_scan_mux (
    .i_board (board),
    .i_xy    (r_index),
    .o_point (w_scan_point)
  );

  assign w_accept = r_scan_valid && scan_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_index       <= '0;
      r_scan_valid  <= 1'b0;
      r_scan_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_black_count <= '0;
      r_white_count <= '0;
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (scan_start) begin
            r_state       <= ST_SCAN;
            r_index       <= '0;
            r_black_count <= '0;
            r_white_count <= '0;
            r_scan_valid  <= 1'b1;
            r_busy        <= 1'b1;
          end
        end

        ST_SCAN: begin
          // scan_start is deliberately ignored here: no restart mid-sweep.
          if (w_accept) begin
            if (w_scan_point == BLACK_CODE) begin
              r_black_count <= r_black_count + 1'b1;
            end
            if (w_scan_point == WHITE_CODE) begin
              r_white_count <= r_white_count + 1'b1;
            end
            if (r_index == LAST_XY) begin
              // Index stays at the last point; it never wraps into a new beat.
              r_state      <= ST_DONE;
              r_scan_valid <= 1'b0;
              r_scan_done  <= 1'b1;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state      <= ST_IDLE;
          r_scan_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign scan_valid  = r_scan_valid;
  assign scan_xy     = r_index;
  assign scan_data   = w_scan_point;
  assign scan_done   = r_scan_done;
  assign busy        = r_busy;
  assign black_count = r_black_count;
  assign white_count = r_white_count;

endmodule

// File: doc/board_memory_read.md
Name: board_memory_read

Overview:
- Read-side counterpart of the board memory write path. Takes the flat 512-bit board image, 16x16 points at 2 bits each, produced by the write path.
- Random-access port: the game controller's single-point queries, such as occupancy checks before a move, with a registered 1-cycle response.
- Sweep engine: streams all 256 points in raster order under a valid/ready handshake to the display/win-check consumers, and tallies black and white stones.

Parameters:
- EMPTY_CODE, 2'b00, point encoding for an empty intersection
- BLACK_CODE, 2'b01, point encoding for a black stone
- WHITE_CODE, 2'b10, point encoding for a white stone (2'b11 is illegal: never counted, passed through unchanged)

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; sampled on rising clock edge
- board  input  512  board image; point (x,y) at board[(x*16+y)*2 +: 2], x = select[7:4], y = select[3:0]
- rd_req  input  1  random-read request, one beat per cycle
- rd_select  input  8  random-read coordinate {x[3:0], y[3:0]}
- rd_valid  output  1  registered: rd_data is valid this cycle
- rd_data  output  2  registered point value for the previous cycle's request
- scan_start  input  1  begin full-board sweep; honoured only in IDLE
- scan_ready  input  1  consumer can accept a sweep beat
- scan_valid  output  1  sweep beat presented
- scan_xy  output  8  coordinate of presented beat
- scan_data  output  2  point value at scan_xy, taken from the live board
- scan_done  output  1  one-cycle pulse after the last beat is accepted
- busy  output  1  high in SCAN and DONE
- black_count  output  9  black stones counted in the current or last sweep, 0..256
- white_count  output  9  white stones counted in the current or last sweep, 0..256

Behaviour:
- Reset: all outputs 0, FSM to IDLE, sweep index 0. Reset mid-sweep aborts the sweep with no scan_done pulse and clears the counts.
- Random read: latency 1.
  - On each edge, rd_valid <= rd_req and rd_data <= board slice at rd_select; rd_data is held when rd_req is 0.
  - Fully independent of the sweep FSM and has no back-pressure. Back-to-back requests give back-to-back responses.
- Sweep FSM, states IDLE, SCAN, DONE:
  - IDLE: scan_valid=0, busy=0. scan_start=1 -> SCAN, index<=0, black_count<=0, white_count<=0.
  - SCAN: scan_valid=1, scan_xy=index, scan_data=board slice at index (combinational from registered index). A beat is accepted when scan_valid && scan_ready.
  - On accept: index<=index+1. black_count increments if scan_data==BLACK_CODE; white_count increments if scan_data==WHITE_CODE.
  - If index==255 on accept -> DONE; the index does not wrap into a new beat.
  - scan_ready=0 holds scan_xy stable. scan_data may change if the board is written meanwhile, and the value at acceptance is the one counted.
  - DONE: scan_valid=0, scan_done=1 for exactly one cycle, busy=1 -> IDLE. Counts are held until the next scan_start.
- scan_start while in SCAN or DONE is ignored, with no restart.
- scan_start and rd_req in the same cycle are both serviced.
- Minimum sweep: 256 cycles of SCAN + 1 cycle of DONE with scan_ready tied high.
- Count width: 9 bits, so an all-black board gives 256 without overflow.

Decomposition:
- Shared package board_pkg holds:
  - point encodings EMPTY/BLACK/WHITE
  - BOARD_DIM=16, POINT_BITS=2, BOARD_BITS=512
  - the coordinate-to-bit-offset function
  - FSM state enum
- Also used by the write path.
- One natural sub-module: board_point_mux, a 512->2 selector indexed by 8-bit xy. It is instantiated twice, once for the random port and once for the sweep.

Test Plan:
- Board with only (3,5)=BLACK; rd_req=1, rd_select=8'h35 -> next cycle rd_valid=1, rd_data=2'b01. rd_select=8'h53 -> rd_data=2'b00.
- Empty board except (0,0)=WHITE and (15,15)=BLACK; scan_start, scan_ready=1:
  - first beat scan_xy=8'h00, data 2'b10; last beat 8'hFF, data 2'b01
  - scan_done pulse exactly 257 cycles after start
  - white_count=1, black_count=1
- Same sweep with scan_ready toggled 1/0 each cycle:
  - scan_xy holds during stalls
  - all 256 coordinates appear exactly once in order
  - counts identical to the previous scenario
- All-black board sweep -> black_count=256, white_count=0. A second scan_start mid-sweep is ignored: a single scan_done.
- Assert reset at beat 100 of a sweep -> next cycle scan_valid=0, busy=0, counts 0, no scan_done. A following scan_start restarts at scan_xy=8'h00.
- rd_req held high while sweeping, rd_select stepping 8'h00..8'h0F -> rd_data tracks each point with 1-cycle latency, and sweep beats are unaffected.
